binary2bcd: RTL and testbench

- Consumer stage directly downstream of the double-to-fixed extractor.
- Requests one conversion result from the extractor (sign, 14-bit integer part, 4-bit fraction, type code) and converts it to packed BCD for display/log paths:
  - integer part → 5 decimal digits, using iterative double-dabble, one shift per clock.
  - fraction part → 4 decimal digits, value f/16 expressed as .dddd.
- Drives the extractor's ready input and consumes its valid output.

---
 rtl/binary2bcd.sv | 182 ++++++++++++++++++
 tb/tb_binary2bcd.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/binary2bcd.sv
// binary2bcd: requests one fixed-point result from the extractor and converts it to packed BCD.
// Optional leading-zero blanking of o_int_bcd when BCD_LZB_EN is defined.
module binary2bcd #(
    parameter int REQ_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    output logic        o_req,
    input  logic        i_valid,
    input  logic        i_sign,
    input  logic [13:0] i_integer,
    input  logic [3:0]  i_fraction,
    input  logic [2:0]  i_type,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_sign,
    output logic [19:0] o_int_bcd,
    output logic [15:0] o_frac_bcd,
    output logic [2:0]  o_type
);

    localparam logic [1:0]  S_IDLE       = 2'd0;
    localparam logic [1:0]  S_REQ        = 2'd1;
    localparam logic [1:0]  S_CONVERT    = 2'd2;
    localparam logic [1:0]  S_DONE       = 2'd3;
    localparam logic [2:0]  TYPE_NORMAL  = 3'd0;
    localparam logic [2:0]  TYPE_TIMEOUT = 3'd5;
    localparam logic [3:0]  LAST_ITER    = 4'd13;
    localparam logic [15:0] TMO_LAST     = 16'(REQ_TIMEOUT - 1);

    logic [1:0]  r_state;
    logic        r_req;
    logic        r_start_pend;
    logic [15:0] r_tmo_cnt;
    logic [3:0]  r_iter;
    logic        r_sign_cap;
    logic [13:0] r_int_bin;
    logic [13:0] r_frac_bin;
    logic [19:0] r_int_acc;
    logic [15:0] r_frac_acc;
    logic        r_sign;
    logic [2:0]  r_type;
    logic [19:0] r_int_bcd;
    logic [15:0] r_frac_bcd;

    logic [13:0] w_frac_in;
    logic [13:0] w_frac_op;
    logic [19:0] w_int_adj;
    logic [15:0] w_frac_adj;
    logic [19:0] w_int_shift;
    logic [15:0] w_frac_shift;
    logic [19:0] w_int_out;

    // f/16 scaled to ten-thousandths: f*625 built from shifts
    assign w_frac_in = {10'd0, i_fraction};
    assign w_frac_op = (w_frac_in << 9) + (w_frac_in << 6) + (w_frac_in << 5)
                     + (w_frac_in << 4) + w_frac_in;

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_int_adj
            assign w_int_adj[gi*4 +: 4] = (r_int_acc[gi*4 +: 4] >= 4'd5) ?
                                          r_int_acc[gi*4 +: 4] + 4'd3 : r_int_acc[gi*4 +: 4];
        end
        for (gi = 0; gi < 4; gi++) begin : g_frac_adj
            assign w_frac_adj[gi*4 +: 4] = (r_frac_acc[gi*4 +: 4] >= 4'd5) ?
                                           r_frac_acc[gi*4 +: 4] + 4'd3 : r_frac_acc[gi*4 +: 4];
        end
    endgenerate

    assign w_int_shift  = {w_int_adj[18:0], r_int_bin[13]};
    assign w_frac_shift = {w_frac_adj[14:0], r_frac_bin[13]};

`ifdef BCD_LZB_EN
    // w_lead_zero[d]: digit d and every digit above it are zero
    logic [4:1] w_lead_zero;
    assign w_lead_zero[4] = (w_int_shift[19:16] == 4'd0);
    generate
        for (gi = 1; gi < 4; gi++) begin : g_lz_chain
            assign w_lead_zero[gi] = w_lead_zero[gi+1] & (w_int_shift[gi*4 +: 4] == 4'd0);
        end
        for (gi = 1; gi < 5; gi++) begin : g_lz_blank
            assign w_int_out[gi*4 +: 4] = w_lead_zero[gi] ? 4'hF : w_int_shift[gi*4 +: 4];
        end
    endgenerate
    assign w_int_out[3:0] = w_int_shift[3:0];
`else
    assign w_int_out = w_int_shift;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_req        <= 1'b0;
            r_start_pend <= 1'b0;
            r_tmo_cnt    <= 16'd0;
            r_iter       <= 4'd0;
            r_sign_cap   <= 1'b0;
            r_int_bin    <= 14'd0;
            r_frac_bin   <= 14'd0;
            r_int_acc    <= 20'd0;
            r_frac_acc   <= 16'd0;
            r_sign       <= 1'b0;
            r_type       <= 3'd0;
            r_int_bcd    <= 20'd0;
            r_frac_bcd   <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // a start seen while the extractor still shows a stale result waits for it to clear
                    if (i_start || r_start_pend) begin
                        if (i_valid) begin
                            r_start_pend <= 1'b1;
                        end else begin
                            r_start_pend <= 1'b0;
                            r_state      <= S_REQ;
                            r_req        <= 1'b1;
                            r_tmo_cnt    <= 16'd0;
                        end
                    end
                end
                S_REQ: begin
                    if (i_valid) begin
                        r_req      <= 1'b0;
                        r_sign_cap <= i_sign;
                        r_int_bin  <= i_integer;
                        r_frac_bin <= w_frac_op;
                        r_int_acc  <= 20'd0;
                        r_frac_acc <= 16'd0;
                        r_iter     <= 4'd0;
                        if (i_type == TYPE_NORMAL) begin
                            r_state <= S_CONVERT;
                        end else begin
                            r_state    <= S_DONE;
                            r_sign     <= i_sign;
                            r_type     <= i_type;
                            r_int_bcd  <= 20'd0;
                            r_frac_bcd <= 16'd0;
                        end
                    end else if ((REQ_TIMEOUT != 0) && (r_tmo_cnt == TMO_LAST)) begin
                        r_req      <= 1'b0;
                        r_state    <= S_DONE;
                        r_sign     <= 1'b0;
                        r_type     <= TYPE_TIMEOUT;
                        r_int_bcd  <= 20'd0;
                        r_frac_bcd <= 16'd0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 16'd1;
                    end
                end
                S_CONVERT: begin
                    r_int_acc  <= w_int_shift;
                    r_frac_acc <= w_frac_shift;
                    r_int_bin  <= {r_int_bin[12:0], 1'b0};
                    r_frac_bin <= {r_frac_bin[12:0], 1'b0};
                    r_iter     <= r_iter + 4'd1;
                    // final step feeds the result registers directly
                    if (r_iter == LAST_ITER) begin
                        r_state    <= S_DONE;
                        r_sign     <= r_sign_cap;
                        r_type     <= TYPE_NORMAL;
                        r_int_bcd  <= w_int_out;
                        r_frac_bcd <= w_frac_shift;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_req      = r_req;
    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = (r_state == S_DONE);
    assign o_sign     = r_sign;
    assign o_int_bcd  = r_int_bcd;
    assign o_frac_bcd = r_frac_bcd;
    assign o_type     = r_type;

endmodule

// File: tb/tb_binary2bcd.sv
// Directed bench for binary2bcd: normal, max, special, timeout, mid-run reset, leading zeros.
// Expected integer digits follow BCD_LZB_EN when the bench is built with it.
module tb_binary2bcd;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic        o_req;
    logic        i_valid;
    logic        i_sign;
    logic [13:0] i_integer;
    logic [3:0]  i_fraction;
    logic [2:0]  i_type;
    logic        o_busy;
    logic        o_done;
    logic        o_sign;
    logic [19:0] o_int_bcd;
    logic [15:0] o_frac_bcd;
    logic [2:0]  o_type;

    int n_total = 0;
    int n_bad   = 0;

`ifdef BCD_LZB_EN
    localparam logic [19:0] EXP_1234 = 20'hF1234;
    localparam logic [19:0] EXP_42   = 20'hFFF42;
    localparam logic [19:0] EXP_7    = 20'hFFFF7;
    localparam logic [19:0] EXP_0    = 20'hFFFF0;
`else
    localparam logic [19:0] EXP_1234 = 20'h01234;
    localparam logic [19:0] EXP_42   = 20'h00042;
    localparam logic [19:0] EXP_7    = 20'h00007;
    localparam logic [19:0] EXP_0    = 20'h00000;
`endif

    binary2bcd #(.REQ_TIMEOUT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .o_req      (o_req),
        .i_valid    (i_valid),
        .i_sign     (i_sign),
        .i_integer  (i_integer),
        .i_fraction (i_fraction),
        .i_type     (i_type),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_sign     (o_sign),
        .o_int_bcd  (o_int_bcd),
        .o_frac_bcd (o_frac_bcd),
        .o_type     (o_type)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    // plays the extractor: answer the first REQ cycle, then measure capture-to-done
    task automatic run_conv(input string tag, input logic s, input logic [13:0] iv,
                            input logic [3:0] fv, input logic [2:0] tv, input int exp_lat,
                            input logic [19:0] exp_int, input logic [15:0] exp_frac);
        int n;
        n = 0;
        while (!o_req && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_req_seen"}, 32'(o_req), 32'd1);
        i_valid    = 1'b1;
        i_sign     = s;
        i_integer  = iv;
        i_fraction = fv;
        i_type     = tv;
        tick();
        i_valid = 1'b0;
        chk({tag, "_req_drop"}, 32'(o_req), 32'd0);
        n = 1;
        while (!o_done && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
        chk({tag, "_done"}, 32'(o_done), 32'd1);
        chk({tag, "_sign"}, 32'(o_sign), 32'(s));
        chk({tag, "_int"}, 32'(o_int_bcd), 32'(exp_int));
        chk({tag, "_frac"}, 32'(o_frac_bcd), 32'(exp_frac));
        chk({tag, "_type"}, 32'(o_type), 32'(tv));
        $display("conv %s int=%05h frac=%04h type=%0d sign=%0d lat=%0d",
                 tag, o_int_bcd, o_frac_bcd, o_type, o_sign, n);
        tick();
        chk({tag, "_done_pulse"}, 32'(o_done), 32'd0);
        chk({tag, "_hold"}, 32'(o_int_bcd), 32'(exp_int));
    endtask

    initial begin
        int n;
        logic seen_done;
        rst = 1'b0;
        i_start = 1'b0;
        i_valid = 1'b0;
        i_sign = 1'b0;
        i_integer = 14'd0;
        i_fraction = 4'd0;
        i_type = 3'd0;
        tick();
        tick();
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_req", 32'(o_req), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_int", 32'(o_int_bcd), 32'd0);
        chk("rst_frac", 32'(o_frac_bcd), 32'd0);
        chk("rst_type", 32'(o_type), 32'd0);
        rst = 1'b1;
        tick();

        pulse_start();
        chk("start_busy", 32'(o_busy), 32'd1);
        run_conv("normal", 1'b0, 14'd1234, 4'd8, 3'd0, 15, EXP_1234, 16'h5000);

        pulse_start();
        run_conv("max", 1'b1, 14'd16383, 4'd15, 3'd0, 15, 20'h16383, 16'h9375);

        pulse_start();
        run_conv("neginf", 1'b1, 14'd5, 4'd3, 3'd3, 1, 20'h00000, 16'h0000);

        pulse_start();
        run_conv("oor", 1'b0, 14'd99, 4'd0, 3'd4, 1, 20'h00000, 16'h0000);

        // stale valid blocks REQ entry, then the request times out
        i_valid = 1'b1;
        pulse_start();
        tick();
        tick();
        chk("block_busy", 32'(o_busy), 32'd0);
        chk("block_req", 32'(o_req), 32'd0);
        i_valid = 1'b0;
        tick();
        chk("release_req", 32'(o_req), 32'd1);
        n = 0;
        while (o_req && n < 30) begin
            n++;
            tick();
        end
        chk("tmo_req_cycles", 32'(n), 32'd8);
        chk("tmo_done", 32'(o_done), 32'd1);
        chk("tmo_type", 32'(o_type), 32'd5);
        chk("tmo_int", 32'(o_int_bcd), 32'd0);
        chk("tmo_frac", 32'(o_frac_bcd), 32'd0);
        $display("timeout req_cycles=%0d type=%0d", n, o_type);
        tick();

        // reset in the 7th CONVERT cycle
        pulse_start();
        i_valid = 1'b1;
        i_sign = 1'b1;
        i_integer = 14'd1234;
        i_fraction = 4'd8;
        i_type = 3'd0;
        tick();
        i_valid = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        chk("mid_busy", 32'(o_busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(o_busy), 32'd0);
        chk("mid_rst_done", 32'(o_done), 32'd0);
        chk("mid_rst_type", 32'(o_type), 32'd0);
        chk("mid_rst_int", 32'(o_int_bcd), 32'd0);
        chk("mid_rst_frac", 32'(o_frac_bcd), 32'd0);
        chk("mid_rst_sign", 32'(o_sign), 32'd0);
        tick();
        rst = 1'b1;
        seen_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (o_done) seen_done = 1'b1;
        end
        chk("mid_no_done", 32'(seen_done), 32'd0);
        $display("midreset busy=%0d done_seen=%0d", o_busy, seen_done);

        pulse_start();
        run_conv("after_rst", 1'b0, 14'd42, 4'd1, 3'd0, 15, EXP_42, 16'h0625);

        pulse_start();
        run_conv("seven", 1'b0, 14'd7, 4'd0, 3'd0, 15, EXP_7, 16'h0000);

        pulse_start();
        run_conv("zero", 1'b1, 14'd0, 4'd2, 3'd0, 15, EXP_0, 16'h1250);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
